// File: rtl/rc_receiver_multi.sv
// N-channel RC PWM receiver: synchronises each pin, measures pulse width in us ticks,
// rejects glitches, scales to VAL_BIT_WIDTH values and falls back to a failsafe value on signal loss.
module rc_receiver_multi #(
    parameter int NUM_CHANNELS    = 6,
    parameter int VAL_BIT_WIDTH   = 8,
    parameter int COUNT_BIT_WIDTH = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int MIN_PULSE_US    = 1000,
    parameter int MAX_PULSE_US    = 2000,
    parameter int MIN_VALID_US    = 500,
    parameter int MAX_VALID_US    = 2500,
    parameter int SCALE_MULT      = 262,
    parameter int SCALE_SHIFT     = 10,
    parameter int TIMEOUT_US      = 25000,
    parameter logic [NUM_CHANNELS-1:0] FAILSAFE_MID_MASK = 6'b111110
) (
    input  logic                                    us_clk,
    input  logic                                    resetn,
    input  logic [NUM_CHANNELS-1:0]                 pwm_in,
    output logic [NUM_CHANNELS*VAL_BIT_WIDTH-1:0]   rec_vals,
    output logic [NUM_CHANNELS-1:0]                 update_strobe,
    output logic                                    valid_strobe,
    output logic [NUM_CHANNELS-1:0]                 chan_valid,
    output logic                                    failsafe
);

    localparam int CW       = COUNT_BIT_WIDTH;
    localparam int VW       = VAL_BIT_WIDTH;
    localparam int PROD_W   = COUNT_BIT_WIDTH + 32;
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    localparam logic [CW-1:0]     CNT_MAX    = '1;
    localparam logic [CW-1:0]     VALID_LO   = CW'(MIN_VALID_US);
    localparam logic [CW-1:0]     VALID_HI   = CW'(MAX_VALID_US);
    localparam logic [CW-1:0]     TIMEOUT_M1 = CW'(TIMEOUT_US - 1);
    localparam logic [PROD_W-1:0] PULSE_LO   = PROD_W'(MIN_PULSE_US);
    localparam logic [PROD_W-1:0] PULSE_HI   = PROD_W'(MAX_PULSE_US);
    localparam logic [PROD_W-1:0] VAL_MAX    = PROD_W'(2 ** VAL_BIT_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    // Synchroniser outputs read 0 right after reset whatever the pin is doing, so WAIT_LOW
    // must not trust them until the chain has been refilled from the pins.
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                settled;

    assign settled = (settle_q == SETTLE_W'(SYNC_STAGES));

    always_comb begin
        settle_d = settle_q;
        if (!settled) settle_d = settle_q + 1'b1;
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) settle_q <= '0;
        else         settle_q <= settle_d;
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        localparam logic [VW-1:0] FS_VAL = FAILSAFE_MID_MASK[g] ? {1'b1, {(VW-1){1'b0}}} : '0;

        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   prev_q, prev_d;
        logic                   sync_out, rise, fall;
        state_t                 state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d, width_q, width_d, to_q, to_d;
        logic                   acc_q, acc_d, upd_q, upd_d, valid_q, valid_d;
        logic [VW-1:0]          val_q, val_d, scaled;
        logic [PROD_W-1:0]      wc, prod;

        assign sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in[g]};
        assign sync_out = sync_q[SYNC_STAGES-1];
        assign prev_d   = sync_out;
        assign rise     = sync_out & ~prev_q;
        assign fall     = ~sync_out & prev_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            width_d = width_q;
            acc_d   = 1'b0;
            case (state_q)
                WAIT_LOW: begin
                    if (settled && !sync_out) state_d = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_d   = CW'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        width_d = cnt_q;
                        acc_d   = (cnt_q >= VALID_LO) && (cnt_q <= VALID_HI);
                        state_d = WAIT_RISE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = WAIT_LOW;
            endcase
        end

        always_comb begin
            wc = PROD_W'(width_q);
            if (wc < PULSE_LO)      wc = PULSE_LO;
            else if (wc > PULSE_HI) wc = PULSE_HI;
            prod   = ((wc - PULSE_LO) * PROD_W'(SCALE_MULT)) >> SCALE_SHIFT;
            scaled = (prod > VAL_MAX) ? '1 : prod[VW-1:0];
        end

        // An accepted update on the same edge as a timeout expiry takes priority.
        always_comb begin
            to_d    = (to_q != CNT_MAX) ? to_q + 1'b1 : to_q;
            val_d   = val_q;
            valid_d = valid_q;
            upd_d   = acc_q;
            if (acc_q) begin
                to_d    = '0;
                val_d   = scaled;
                valid_d = 1'b1;
            end else if (to_q >= TIMEOUT_M1) begin
                val_d   = FS_VAL;
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge us_clk or negedge resetn) begin
            if (!resetn) begin
                sync_q  <= '0;
                prev_q  <= 1'b0;
                state_q <= WAIT_LOW;
                cnt_q   <= '0;
                width_q <= '0;
                acc_q   <= 1'b0;
                to_q    <= '0;
                val_q   <= FS_VAL;
                upd_q   <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                prev_q  <= prev_d;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                width_q <= width_d;
                acc_q   <= acc_d;
                to_q    <= to_d;
                val_q   <= val_d;
                upd_q   <= upd_d;
                valid_q <= valid_d;
            end
        end

        assign rec_vals[g*VW +: VW] = val_q;
        assign update_strobe[g]     = upd_q;
        assign chan_valid[g]        = valid_q;
    end

    assign valid_strobe = |update_strobe;
    assign failsafe     = ~&chan_valid;

endmodule

// File: tb/tb_rc_receiver_multi.sv
// Directed bench for rc_receiver_multi: drives PWM pulses and checks values, strobes,
// latency, timeout failsafe and reset behaviour with immediate assertions.
module tb_rc_receiver_multi;

    logic        us_clk = 1'b0;
    logic        resetn;
    logic [5:0]  pwm_in;
    logic [47:0] rec_vals;
    logic [5:0]  update_strobe;
    logic        valid_strobe;
    logic [5:0]  chan_valid;
    logic        failsafe;

    rc_receiver_multi dut (
        .us_clk        (us_clk),
        .resetn        (resetn),
        .pwm_in        (pwm_in),
        .rec_vals      (rec_vals),
        .update_strobe (update_strobe),
        .valid_strobe  (valid_strobe),
        .chan_valid    (chan_valid),
        .failsafe      (failsafe)
    );

    initial forever #5 us_clk = ~us_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge us_clk) cyc <= cyc + 1;

    int         wid [6];
    int         first_idx;
    int         strobe_cyc;
    int         upd_total;
    int         vs_cnt;
    logic [5:0] upd_first;
    int         c0;
    int         target;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] val(input int ch);
        return rec_vals[ch*8 +: 8];
    endfunction

    task automatic monitor();
        first_idx = 0;
        upd_total = 0;
        vs_cnt    = 0;
        upd_first = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge us_clk);
            #1;
            if ((update_strobe != 6'b0) && (first_idx == 0)) begin
                first_idx  = k;
                strobe_cyc = cyc;
                upd_first  = update_strobe;
            end
            for (int i = 0; i < 6; i++) upd_total += int'(update_strobe[i]);
            vs_cnt += int'(valid_strobe);
        end
    endtask

    // Pulses are stacked so every active channel falls on the same clock.
    task automatic run_pulses();
        int maxw;
        maxw = 0;
        for (int i = 0; i < 6; i++) if (wid[i] > maxw) maxw = wid[i];
        for (int t = 0; t < maxw; t++) begin
            @(negedge us_clk);
            for (int i = 0; i < 6; i++) pwm_in[i] = (wid[i] != 0) && (t >= maxw - wid[i]);
        end
        @(negedge us_clk);
        pwm_in = '0;
        monitor();
    endtask

    task automatic single(input int ch, input int w);
        for (int i = 0; i < 6; i++) wid[i] = 0;
        wid[ch] = w;
        run_pulses();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        pwm_in = '0;
        repeat (5) @(negedge us_clk);
        chk("reset_vals",   64'(rec_vals),      64'h8080_8080_8000);
        chk("reset_upd",    64'(update_strobe), 64'h0);
        chk("reset_vs",     64'(valid_strobe),  64'h0);
        chk("reset_cvalid", 64'(chan_valid),    64'h0);
        chk("reset_fs",     64'(failsafe),      64'h1);
        resetn = 1'b1;
        repeat (10) @(negedge us_clk);

        single(0, 1500);
        chk("p1500_latency", 64'(first_idx),     64'd4);
        chk("p1500_upd",     64'(upd_total),     64'd1);
        chk("p1500_vs",      64'(vs_cnt),        64'd1);
        chk("p1500_val",     64'(val(0)),        64'd127);
        chk("p1500_cvalid",  64'(chan_valid[0]), 64'h1);

        single(0, 2000);
        chk("p2000_val", 64'(val(0)),    64'd255);
        single(0, 2200);
        chk("p2200_upd", 64'(upd_total), 64'd1);
        chk("p2200_val", 64'(val(0)),    64'd255);
        single(0, 900);
        chk("p900_upd",  64'(upd_total), 64'd1);
        chk("p900_val",  64'(val(0)),    64'd0);
        single(0, 1000);
        chk("p1000_val", 64'(val(0)),    64'd0);
        single(0, 1500);
        single(0, 500);
        chk("p500_upd",  64'(upd_total), 64'd1);
        chk("p500_val",  64'(val(0)),    64'd0);

        for (int i = 0; i < 6; i++) wid[i] = 0;
        wid[0] = 1500;
        wid[1] = 1700;
        run_pulses();
        c0 = strobe_cyc;
        chk("dual_upd",    64'(upd_first),       64'h03);
        chk("dual_vs",     64'(vs_cnt),          64'd1);
        chk("dual_val0",   64'(val(0)),          64'd127);
        chk("dual_val1",   64'(val(1)),          64'd179);
        chk("dual_cvalid", 64'(chan_valid[1:0]), 64'h3);

        single(0, 300);
        chk("g300_upd",  64'(upd_total), 64'd0);
        chk("g300_vs",   64'(vs_cnt),    64'd0);
        chk("g300_val",  64'(val(0)),    64'd127);
        single(0, 2600);
        chk("g2600_upd", 64'(upd_total), 64'd0);
        chk("g2600_val", 64'(val(0)),    64'd127);

        target = c0 + 24999;
        do begin
            @(posedge us_clk);
            #1;
        end while (cyc < target);
        chk("to_before_cvalid", 64'(chan_valid[1:0]), 64'h3);
        chk("to_before_val0",   64'(val(0)),          64'd127);
        @(posedge us_clk);
        #1;
        chk("to_cvalid", 64'(chan_valid[1:0]), 64'h0);
        chk("to_val0",   64'(val(0)),          64'd0);
        chk("to_val1",   64'(val(1)),          64'd128);
        chk("to_fs",     64'(failsafe),        64'h1);

        single(1, 1250);
        chk("resume_val1",   64'(val(1)),        64'd63);
        chk("resume_cvalid", 64'(chan_valid[1]), 64'h1);

        @(negedge us_clk);
        pwm_in[2] = 1'b1;
        repeat (500) @(negedge us_clk);
        resetn = 1'b0;
        repeat (3) @(negedge us_clk);
        chk("midrst_vals",   64'(rec_vals),   64'h8080_8080_8000);
        chk("midrst_cvalid", 64'(chan_valid), 64'h0);
        resetn = 1'b1;
        repeat (700) @(negedge us_clk);
        pwm_in[2] = 1'b0;
        monitor();
        chk("midrst_upd",  64'(upd_total), 64'd0);
        chk("midrst_val2", 64'(val(2)),    64'd128);
        single(2, 1200);
        chk("p1200_upd",  64'(upd_total), 64'd1);
        chk("p1200_val2", 64'(val(2)),    64'd51);

        wid[0] = 1100;
        wid[1] = 1300;
        wid[2] = 1500;
        wid[3] = 1700;
        wid[4] = 1900;
        wid[5] = 2100;
        run_pulses();
        chk("all6_latency", 64'(first_idx),  64'd4);
        chk("all6_upd",     64'(upd_first),  64'h3f);
        chk("all6_total",   64'(upd_total),  64'd6);
        chk("all6_vs",      64'(vs_cnt),     64'd1);
        chk("all6_vals",    64'(rec_vals),   64'hFFE6_B37F_4C19);
        chk("all6_cvalid",  64'(chan_valid), 64'h3f);
        chk("all6_fs",      64'(failsafe),   64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
